// File: rtl/bch_15_7_enc_seq_if.sv
// bch_15_7_enc_seq_if: message-in / codeword-out valid/ready bundle for the BCH(15,7) encoder.
// Revision 1.0 - initial release.
`default_nettype none

interface bch_15_7_enc_seq_if;
  logic        i_valid;
  logic        i_ready;
  logic [6:0]  i_data;
  logic        o_valid;
  logic        o_ready;
  logic [14:0] o_codeword;

  // master = upstream producer of messages and consumer of codewords
  modport master (
    output i_valid, i_data, o_ready,
    input  i_ready, o_valid, o_codeword
  );

  modport slave (
    input  i_valid, i_data, o_ready,
    output i_ready, o_valid, o_codeword
  );
endinterface

`default_nettype wire

// File: rtl/bch_15_7_enc_seq.sv
// bch_15_7_enc_seq: serial-LFSR systematic BCH(15,7) encoder, one message bit per cycle.
// Optional macro ERROR_INJECT_EN adds i_err_mask XORed onto the codeword. Revision 1.0.
`default_nettype none

module bch_15_7_enc_seq #(
  parameter logic [7:0] POLY = 8'hD1,
  parameter int         N    = 15,
  parameter int         K    = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bch_15_7_enc_seq_if.slave     bus,
  output logic                  o_busy
`ifdef ERROR_INJECT_EN
  ,
  input  logic [N-1:0]          i_err_mask
`endif
);

  localparam int CW = $clog2(K + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]     state;
  logic [1:0]     state_next;
  logic [K-1:0]   msg;
  logic [N-K-1:0] lfsr;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   codeword;

  logic           accept;
  logic           last_shift;
  logic           fb;
  logic [N-K-1:0] lfsr_next;
  logic [N-1:0]   codeword_next;

`ifdef ERROR_INJECT_EN
  logic [N-1:0]   mask;
`endif

  assign accept     = bus.i_valid && (state == ST_IDLE);
  assign last_shift = (state == ST_SHIFT) && (cnt == CW'(K - 1));

  // Message bits enter MSB first; feedback is the incoming bit XOR the LFSR top bit.
  assign fb        = msg[CW'(K - 1) - cnt] ^ lfsr[N-K-1];
  assign lfsr_next = {lfsr[N-K-2:0], 1'b0} ^ (fb ? POLY : '0);

`ifdef ERROR_INJECT_EN
  assign codeword_next = {msg, lfsr_next} ^ mask;
`else
  assign codeword_next = {msg, lfsr_next};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (accept)      state_next = ST_SHIFT;
      ST_SHIFT: if (last_shift)  state_next = ST_DONE;
      ST_DONE:  if (bus.o_ready) state_next = ST_IDLE;
      default:                   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.i_ready    = (state == ST_IDLE);
    bus.o_valid    = (state == ST_DONE);
    bus.o_codeword = codeword;
    o_busy         = (state != ST_IDLE);
  end

  // Codeword is held after the output handshake; only a new word or reset changes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      msg      <= '0;
      lfsr     <= '0;
      cnt      <= '0;
      codeword <= '0;
`ifdef ERROR_INJECT_EN
      mask     <= '0;
`endif
    end else if (accept) begin
      msg  <= bus.i_data;
      lfsr <= '0;
      cnt  <= '0;
`ifdef ERROR_INJECT_EN
      mask <= i_err_mask;
`endif
    end else if (state == ST_SHIFT) begin
      lfsr <= lfsr_next;
      cnt  <= cnt + CW'(1);
      if (last_shift) begin
        codeword <= codeword_next;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bch_15_7_enc_seq.sv
// tb_bch_15_7_enc_seq: directed table vectors plus stall, mid-shift reset and exhaustive
// divisibility checks for bch_15_7_enc_seq.
`default_nettype none

module tb_bch_15_7_enc_seq;

  typedef struct {
    logic [6:0]  msg;
    logic [14:0] cw;
  } vec_t;

  logic clk;
  logic rst_n;
  logic o_busy;
  int   cyc;
  int   checks;
  int   failures;

`ifdef ERROR_INJECT_EN
  logic [14:0] err_mask;
`endif

  bch_15_7_enc_seq_if bus ();

  bch_15_7_enc_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .o_busy     (o_busy)
`ifdef ERROR_INJECT_EN
    ,
    .i_err_mask (err_mask)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Independent codeword test: remainder of the full 15-bit word divided by g(x).
  function automatic logic [7:0] rem15(input logic [14:0] w);
    logic [14:0] r;
    logic [14:0] g;
    r = w;
    g = 15'h01D1;
    for (int i = 14; i >= 8; i--) begin
      if (r[i]) r = r ^ (g << (i - 8));
    end
    return r[7:0];
  endfunction

  // Called at a negedge; returns the cycle count at the negedge after the accept edge.
  task automatic send(input logic [6:0] m, output int t_acc);
    int n;
    n = 0;
    bus.i_valid = 1'b1;
    bus.i_data  = m;
    while (!bus.i_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.i_ready) check("accept_timeout", 32'(bus.i_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    t_acc       = cyc;
    bus.i_valid = 1'b0;
    bus.i_data  = 7'h00;
  endtask

  task automatic wait_ov(output int t_ov);
    int n;
    n = 0;
    while (!bus.o_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.o_valid) check("valid_timeout", 32'(bus.o_valid), 32'd1);
    t_ov = cyc;
  endtask

  vec_t vecs[5];

  initial begin
    int ta;
    int ta_prev;
    int tv;

    vecs[0] = '{msg: 7'h01, cw: 15'h01D1};
    vecs[1] = '{msg: 7'h02, cw: 15'h0273};
    vecs[2] = '{msg: 7'h03, cw: 15'h03A2};
    vecs[3] = '{msg: 7'h00, cw: 15'h0000};
    vecs[4] = '{msg: 7'h7F, cw: 15'h7FFF};

    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_data  = 7'h00;
    bus.o_ready = 1'b0;
`ifdef ERROR_INJECT_EN
    err_mask    = 15'h0000;
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_o_valid", 32'(bus.o_valid), 32'd0);
    check("rst_codeword", 32'(bus.o_codeword), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_i_ready", 32'(bus.i_ready), 32'd1);

    // Back-to-back table vectors with o_ready held high.
    bus.o_ready = 1'b1;
    ta_prev = 0;
    for (int i = 0; i < 5; i++) begin
      send(vecs[i].msg, ta);
      if (i > 0) check($sformatf("b2b_spacing_%0d", i), 32'(ta - ta_prev), 32'd9);
      check($sformatf("busy_shift_%0d", i), 32'(o_busy), 32'd1);
      wait_ov(tv);
      check($sformatf("latency_%0d", i), 32'(tv - ta), 32'd7);
      check($sformatf("codeword_%0d", i), 32'(bus.o_codeword), 32'(vecs[i].cw));
      check($sformatf("no_bypass_%0d", i), 32'(bus.i_ready), 32'd0);
      @(negedge clk);
      check($sformatf("idle_ready_%0d", i), {30'd0, bus.i_ready, bus.o_valid}, 32'b10);
      ta_prev = ta;
    end

    // Output stall: codeword held, input ignored until o_ready.
    bus.o_ready = 1'b0;
    send(7'h01, ta);
    wait_ov(tv);
    for (int i = 0; i < 20; i++) begin
      bus.i_valid = 1'b1;
      bus.i_data  = 7'(7'h55 + i);
      @(negedge clk);
      check($sformatf("stall_hold_%0d", i), {15'd0, bus.o_valid, bus.i_ready, bus.o_codeword},
            {15'd0, 1'b1, 1'b0, 15'h01D1});
    end
    bus.i_valid = 1'b0;
    bus.o_ready = 1'b1;
    @(negedge clk);
    check("stall_release", {29'd0, bus.o_valid, bus.i_ready, o_busy}, 32'b010);
    check("stall_hold_after", 32'(bus.o_codeword), 32'h01D1);

    // Reset asserted three cycles into SHIFT drops the word.
    send(7'h7F, ta);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_state", {29'd0, bus.o_valid, o_busy, bus.i_ready}, 32'b001);
    check("midrst_codeword", 32'(bus.o_codeword), 32'd0);
    send(7'h02, ta);
    wait_ov(tv);
    check("midrst_latency", 32'(tv - ta), 32'd7);
    check("midrst_codeword_after", 32'(bus.o_codeword), 32'h0273);
    @(negedge clk);

    // All messages: systematic part equals the message and the word is divisible by g(x).
    for (int m = 0; m < 128; m++) begin
      send(7'(m), ta);
      wait_ov(tv);
      check($sformatf("exh_msg_%0d", m), 32'(bus.o_codeword[14:8]), 32'(m));
      check($sformatf("exh_rem_%0d", m), 32'(rem15(bus.o_codeword)), 32'd0);
    end
    @(negedge clk);

`ifdef ERROR_INJECT_EN
    err_mask = 15'h0005;
    send(7'h01, ta);
    err_mask = 15'h7000;
    wait_ov(tv);
    check("inject_codeword", 32'(bus.o_codeword), 32'h01D4);
    check("inject_syndrome", 32'(rem15(bus.o_codeword)), 32'h05);
    check("inject_corrected", 32'(bus.o_codeword ^ 15'h0005), 32'h01D1);
    @(negedge clk);
    err_mask = 15'h0000;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
